// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the WB stage of the RV32I pipeline.
package writeback_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        WB_SEL_ALU  = 1'b0,
        WB_SEL_LOAD = 1'b1
    } wb_sel_e;

    // MEM/WB pipeline register contents
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        wb_sel_e               wb_sel;
        logic [2:0]            funct3;
        logic [XLEN-1:0]       alu_result;
    } mem_wb_t;

endpackage

// File: rtl/writeback_unit_load_aligner.sv
// Selects and extends the addressed byte/halfword of a load word.
module writeback_unit_load_aligner
    import writeback_unit_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, then sign/zero extension by load type
    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN - 8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(XLEN - 16){half_v[15]}}, half_v};
            F3_LW:   data = word;
            F3_LBU:  data = {{(XLEN - 8){1'b0}}, byte_v};
            F3_LHU:  data = {{(XLEN - 16){1'b0}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// WB stage: MEM/WB register, load alignment, register file write port,
// same-cycle operand bypass and the pending-write scoreboard for RAW stalls.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_wb_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [XLEN-1:0]       mem_alu_result,
    input  logic [XLEN-1:0]       dm_rdata,
    input  logic                  id_issue,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]       RS1Data,
    input  logic [XLEN-1:0]       RS2Data,
    input  logic                  kill_valid,
    input  logic [REG_ADDR_W-1:0] kill_rd_addr,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WB_rd_addr,
    output logic [XLEN-1:0]       WB_rd_data,
    output logic [XLEN-1:0]       op_rs1_data,
    output logic [XLEN-1:0]       op_rs2_data,
    output logic                  id_stall
);

    mem_wb_t         wb_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [XLEN-1:0] load_data;
    logic            haz1;
    logic            haz2;

    // MEM/WB register; mem_valid=0 simply captures a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q.valid      <= mem_valid;
            wb_q.reg_write  <= mem_reg_write;
            wb_q.rd         <= mem_rd_addr;
            wb_q.wb_sel     <= wb_sel_e'(mem_wb_sel);
            wb_q.funct3     <= mem_funct3;
            wb_q.alu_result <= mem_alu_result;
        end
    end

    writeback_unit_load_aligner u_load_aligner (
        .funct3 (wb_q.funct3),
        .offset (wb_q.alu_result[1:0]),
        .word   (dm_rdata),
        .data   (load_data)
    );

    // Register file write port and bypass of the same-cycle write
    always_comb begin
        RegWrite    = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
        WB_rd_addr  = wb_q.rd;
        WB_rd_data  = (wb_q.wb_sel == WB_SEL_LOAD) ? load_data : wb_q.alu_result;
        op_rs1_data = (RegWrite && (WB_rd_addr == id_rs1_addr) && (id_rs1_addr != '0)) ?
                      WB_rd_data : RS1Data;
        op_rs2_data = (RegWrite && (WB_rd_addr == id_rs2_addr) && (id_rs2_addr != '0)) ?
                      WB_rd_data : RS2Data;
    end

    // Scoreboard next state: clears first so a same-address issue wins
    always_comb begin
        busy_d = busy_q;
        if (RegWrite) begin
            busy_d[WB_rd_addr] = 1'b0;
        end
        if (kill_valid) begin
            busy_d[kill_rd_addr] = 1'b0;
        end
        if (id_issue && (id_rd_addr != '0)) begin
            busy_d[id_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // RAW stall; a producer in WB this cycle is bypassed instead
    always_comb begin
        haz1     = busy_q[id_rs1_addr] & ~(RegWrite & (WB_rd_addr == id_rs1_addr));
        haz2     = busy_q[id_rs2_addr] & ~(RegWrite & (WB_rd_addr == id_rs2_addr));
        id_stall = haz1 | haz2;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit with a writeback scoreboard.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd_addr;
    logic        mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result;
    logic [31:0] dm_rdata;
    logic        id_issue;
    logic [4:0]  id_rd_addr;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] RS1Data;
    logic [31:0] RS2Data;
    logic        kill_valid;
    logic [4:0]  kill_rd_addr;
    logic        RegWrite;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;
    logic [31:0] op_rs1_data;
    logic [31:0] op_rs2_data;
    logic        id_stall;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] dm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [31:0] DM = 32'h80FF_7F01;

    writeback_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd_addr    (mem_rd_addr),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .dm_rdata       (dm_rdata),
        .id_issue       (id_issue),
        .id_rd_addr     (id_rd_addr),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .RS1Data        (RS1Data),
        .RS2Data        (RS2Data),
        .kill_valid     (kill_valid),
        .kill_rd_addr   (kill_rd_addr),
        .RegWrite       (RegWrite),
        .WB_rd_addr     (WB_rd_addr),
        .WB_rd_data     (WB_rd_data),
        .op_rs1_data    (op_rs1_data),
        .op_rs2_data    (op_rs2_data),
        .id_stall       (id_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction to MEM for the next edge and record what WB must show
    task automatic drive_mem(input logic rw, input logic [4:0] rd, input logic sel,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] dm, input logic [31:0] exp_data);
        exp_t e;
        mem_valid      = 1'b1;
        mem_reg_write  = rw;
        mem_rd_addr    = rd;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
        e.we   = rw && (rd != 5'd0);
        e.rd   = rd;
        e.data = exp_data;
        e.dm   = dm;
        sb.push_back(e);
    endtask

    task automatic drive_bubble(input logic [4:0] rd);
        exp_t e;
        mem_valid     = 1'b0;
        mem_reg_write = 1'b1;
        mem_rd_addr   = rd;
        e.we   = 1'b0;
        e.rd   = rd;
        e.data = '0;
        e.dm   = '0;
        sb.push_back(e);
    endtask

    // Advance one edge; the MEM input defaults back to a bubble afterwards
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            dm_rdata = e.dm;
            #1;
            check_eq("wb_we", {31'd0, RegWrite}, {31'd0, e.we});
            if (e.we) begin
                check_eq("wb_addr", {27'd0, WB_rd_addr}, {27'd0, e.rd});
                check_eq("wb_data", WB_rd_data, e.data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_reg_write = 0; mem_rd_addr = 0; mem_wb_sel = 0;
        mem_funct3 = 0; mem_alu_result = 0; dm_rdata = 0;
        id_issue = 0; id_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        RS1Data = 0; RS2Data = 0; kill_valid = 0; kill_rd_addr = 0;
        #12;
        check_eq("rst_we", {31'd0, RegWrite}, 32'd0);
        check_eq("rst_addr", {27'd0, WB_rd_addr}, 32'd0);
        check_eq("rst_data", WB_rd_data, 32'd0);
        check_eq("rst_stall", {31'd0, id_stall}, 32'd0);
        rst = 1'b0;

        // ALU result, loads of every type/offset, non-load funct3 and bubbles
        drive_mem(1, 5'd5, 0, 3'b000, 32'h1234_5678, DM, 32'h1234_5678); tick();
        drive_mem(1, 5'd6, 1, 3'b000, 32'h0000_1003, DM, 32'hFFFF_FF80); tick();
        drive_mem(1, 5'd6, 1, 3'b100, 32'h0000_1003, DM, 32'h0000_0080); tick();
        drive_mem(1, 5'd6, 1, 3'b001, 32'h0000_1002, DM, 32'hFFFF_80FF); tick();
        drive_mem(1, 5'd6, 1, 3'b101, 32'h0000_1000, DM, 32'h0000_7F01); tick();
        drive_mem(1, 5'd6, 1, 3'b010, 32'h0000_1001, DM, 32'h80FF_7F01); tick();
        drive_mem(1, 5'd6, 1, 3'b001, 32'h0000_1003, DM, 32'hFFFF_80FF); tick();
        drive_mem(1, 5'd6, 1, 3'b000, 32'h0000_1000, DM, 32'h0000_0001); tick();
        drive_mem(1, 5'd6, 1, 3'b000, 32'h0000_1001, DM, 32'h0000_007F); tick();
        drive_mem(1, 5'd6, 1, 3'b101, 32'h0000_1002, DM, 32'h0000_80FF); tick();
        drive_mem(1, 5'd6, 1, 3'b011, 32'h0000_1002, DM, 32'h80FF_7F01); tick();
        drive_mem(1, 5'd8, 0, 3'b000, 32'hA5A5_0003, DM, 32'hA5A5_0003); tick();
        drive_mem(0, 5'd8, 0, 3'b000, 32'h1111_1111, DM, 32'h1111_1111); tick();
        drive_bubble(5'd8); tick();
        drive_mem(1, 5'd0, 0, 3'b000, 32'h2222_2222, DM, 32'h2222_2222); tick();

        // x0 is never tracked, never stalls and never bypasses
        id_issue = 1; id_rd_addr = 5'd0; tick(); id_issue = 0;
        id_rs1_addr = 5'd0; RS1Data = 32'h1111_0000; #1;
        check_eq("x0_stall", {31'd0, id_stall}, 32'd0);
        check_eq("x0_op", op_rs1_data, 32'h1111_0000);

        // RAW stall on rd=7 until its WB cycle, then bypass
        id_issue = 1; id_rd_addr = 5'd7; tick(); id_issue = 0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd7; #1;
        check_eq("stall_rs2", {31'd0, id_stall}, 32'd1);
        id_rs2_addr = 5'd0; id_rs1_addr = 5'd7; RS1Data = 32'hDEAD_BEEF; #1;
        check_eq("stall_rs1", {31'd0, id_stall}, 32'd1);
        check_eq("nobyp_rs1", op_rs1_data, 32'hDEAD_BEEF);
        tick(); #1;
        check_eq("stall_hold", {31'd0, id_stall}, 32'd1);
        drive_mem(1, 5'd7, 0, 3'b000, 32'hCAFE_0007, DM, 32'hCAFE_0007); tick();
        id_rs2_addr = 5'd3; RS2Data = 32'h0000_0033; #1;
        check_eq("wb_nostall", {31'd0, id_stall}, 32'd0);
        check_eq("byp_rs1", op_rs1_data, 32'hCAFE_0007);
        check_eq("nobyp_rs2", op_rs2_data, 32'h0000_0033);
        tick(); #1;
        check_eq("busy7_clr", {31'd0, id_stall}, 32'd0);
        check_eq("after_rs1", op_rs1_data, 32'hDEAD_BEEF);
        id_rs2_addr = 5'd0;

        // Same-cycle WB clear and reissue on rd=9: set wins
        id_issue = 1; id_rd_addr = 5'd9; tick(); id_issue = 0;
        id_rs1_addr = 5'd9; #1;
        check_eq("busy9", {31'd0, id_stall}, 32'd1);
        drive_mem(1, 5'd9, 0, 3'b000, 32'h0000_0009, DM, 32'h0000_0009); tick();
        id_issue = 1; id_rd_addr = 5'd9; tick(); id_issue = 0; #1;
        check_eq("set_wins", {31'd0, id_stall}, 32'd1);

        // Kill rd=9 and WB rd=4 in one cycle clear both
        id_issue = 1; id_rd_addr = 5'd4; tick(); id_issue = 0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd4; #1;
        check_eq("busy4", {31'd0, id_stall}, 32'd1);
        drive_mem(1, 5'd4, 0, 3'b000, 32'h0000_0004, DM, 32'h0000_0004); tick();
        kill_valid = 1; kill_rd_addr = 5'd9; tick(); kill_valid = 0;
        id_rs1_addr = 5'd9; id_rs2_addr = 5'd0; #1;
        check_eq("kill9_clr", {31'd0, id_stall}, 32'd0);
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd4; #1;
        check_eq("wb4_clr", {31'd0, id_stall}, 32'd0);
        id_rs2_addr = 5'd0;

        // Async reset with a load in WB and a pending producer
        id_issue = 1; id_rd_addr = 5'd15;
        drive_mem(1, 5'd12, 1, 3'b000, 32'h0000_2003, DM, 32'hFFFF_FF80); tick();
        id_issue = 0; id_rs1_addr = 5'd15; #1;
        check_eq("pre_rst_stall", {31'd0, id_stall}, 32'd1);
        rst = 1'b1; #1;
        check_eq("arst_we", {31'd0, RegWrite}, 32'd0);
        check_eq("arst_data", WB_rd_data, 32'd0);
        check_eq("arst_stall", {31'd0, id_stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_we", {31'd0, RegWrite}, 32'd0);
        check_eq("post_rst_stall", {31'd0, id_stall}, 32'd0);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
